// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the multi-port RAM front-end arbiter.
package ram_arb_pkg;

  localparam int NPORTS_MAX = 8;

  typedef logic [$clog2(NPORTS_MAX)-1:0] port_id_t;

  // Round-robin pick over a request vector padded to NPORTS_MAX bits.
  // Padding bits above the real port count are always zero, so wrapping
  // at NPORTS_MAX gives the same winner as wrapping at the real count.
  function automatic logic [NPORTS_MAX-1:0] rr_pick(input logic [NPORTS_MAX-1:0] req,
                                                   input port_id_t ptr);
    logic [NPORTS_MAX-1:0] gnt;
    logic                  found;
    port_id_t              idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NPORTS_MAX; k++) begin
      idx = ptr + port_id_t'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ram_port_arb_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which port issued each read so that
// in-order read data can be steered back to its requester.
module tag_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  port_id_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == CNT_W'(0));
  assign head  = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pushes into a full FIFO and pops
  // from an empty one are ignored.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_id;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/ram_port_arb.sv
// Multi-port front-end for the DDR3 controller wrapper: round-robin request
// arbitration, posted writes, bounded outstanding reads with response steering.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int NPORTS    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS-1:0]              req_valid,
  output logic [NPORTS-1:0]              req_ready,
  input  logic [NPORTS-1:0]              req_we,
  input  logic [NPORTS*ADDR_W-1:0]       req_addr,
  input  logic [NPORTS*DATA_W-1:0]       req_wdata,
  input  logic [NPORTS*(DATA_W/8)-1:0]   req_be,
  output logic [NPORTS-1:0]              rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic [DATA_W/8-1:0]            mem_wmask,
  output logic                           mem_read_req,
  output logic                           mem_write_req,
  input  logic                           mem_read_ready,
  input  logic                           mem_write_ready,
  input  logic                           mem_read_data_valid,
  input  logic [DATA_W-1:0]              mem_read_data,
  output logic                           err_unexp
);

  localparam int BE_W = DATA_W / 8;

  logic [NPORTS-1:0]     elig_s, gnt_s;
  logic [NPORTS_MAX-1:0] elig_pad_s, gnt_pad_s;
  logic                  gnt_any_s, gnt_we_s;
  port_id_t              gnt_idx_s;
  logic                  fifo_full_s, fifo_empty_s, push_s, pop_s;
  port_id_t              head_s;
  port_id_t              rr_ptr_q, rr_ptr_d;
  logic [NPORTS-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;

  // Eligibility and round-robin grant; a read is only eligible while the
  // tag FIFO has room, even if a pop happens in the same cycle.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      elig_s[i] = req_valid[i] & (req_we[i] ? mem_write_ready
                                            : (mem_read_ready & ~fifo_full_s));
    end
    elig_pad_s             = '0;
    elig_pad_s[NPORTS-1:0] = elig_s;
    gnt_pad_s              = rr_pick(elig_pad_s, rr_ptr_q);
    gnt_s                  = gnt_pad_s[NPORTS-1:0];
    gnt_any_s              = |gnt_pad_s;
    gnt_idx_s              = '0;
    for (int k = 0; k < NPORTS_MAX; k++) begin
      gnt_idx_s = gnt_pad_s[k] ? port_id_t'(k) : gnt_idx_s;
    end
  end

  // Downstream bus mux: one-hot AND-OR select, all zero when nothing is granted.
  // The write mask is only meaningful for writes and is zero on reads.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    gnt_we_s  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      mem_addr  = mem_addr  | ({ADDR_W{gnt_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
      mem_wdata = mem_wdata | ({DATA_W{gnt_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
      mem_wmask = mem_wmask | ({BE_W{gnt_s[i] & req_we[i]}} & req_be[i*BE_W +: BE_W]);
      gnt_we_s  = gnt_we_s  | (gnt_s[i] & req_we[i]);
    end
    mem_read_req  = gnt_any_s & ~gnt_we_s;
    mem_write_req = gnt_any_s & gnt_we_s;
  end

  assign req_ready = gnt_s;
  assign push_s    = gnt_any_s & ~gnt_we_s;
  assign pop_s     = mem_read_data_valid & ~fifo_empty_s;

  tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .push_id (gnt_idx_s),
    .pop     (pop_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (head_s)
  );

  // Next round-robin pointer, response stage contents and sticky error.
  always_comb begin
    if (gnt_any_s) begin
      rr_ptr_d = (gnt_idx_s == port_id_t'(NPORTS - 1)) ? port_id_t'(0)
                                                       : gnt_idx_s + port_id_t'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < NPORTS; i++) begin
      rsp_valid_d[i] = pop_s & (head_s == port_id_t'(i));
    end
    rsp_rdata_d = pop_s ? mem_read_data : rsp_rdata_q;
    err_d       = err_q | (mem_read_data_valid & fifo_empty_s);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= port_id_t'(0);
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_ram_port_arb.sv
// Self-checking bench for ram_port_arb: directed scenarios plus randomized
// traffic against a queue-based reference model and a response scoreboard.
module tb_ram_port_arb;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*BW-1:0]  req_be;
  logic [DW-1:0]     rsp_rdata, mem_wdata, mem_read_data;
  logic [AW-1:0]     mem_addr;
  logic [BW-1:0]     mem_wmask;
  logic              mem_read_req, mem_write_req, mem_read_ready, mem_write_ready;
  logic              mem_read_data_valid, err_unexp;

  always #5 clk = ~clk;

  ram_port_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_read_data_valid(mem_read_data_valid), .mem_read_data(mem_read_data),
    .err_unexp(err_unexp)
  );

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;

  // Reference model state: reads in flight (by port), pending responses,
  // round-robin start point and the expected error flag.
  rsp_t exp_rsp[$];
  int   outst[$];
  int   rr;
  bit   exp_err;
  int   exp_g;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // The lowest-numbered eligible port at or after rr wins, wrapping.
  function automatic int model_grant();
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (rr + k) % NP;
      if (req_valid[p] && (req_we[p] ? mem_write_ready
                                     : (mem_read_ready && outst.size() < MO)))
        return p;
    end
    return -1;
  endfunction

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_read_ready = 1'b1; mem_write_ready = 1'b1;
    mem_read_data_valid = 1'b0; mem_read_data = '0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[p]           = 1'b1;
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
    req_be[p*BW +: BW]     = be;
  endtask

  // Compare the combinational issue path against the model once inputs settle.
  task automatic settle_check();
    logic [NP-1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] em;
    bit            ew;
    #1;
    exp_g = model_grant();
    if (rst_n) begin
      eg = '0; ea = '0; ed = '0; em = '0; ew = 1'b0;
      if (exp_g >= 0) begin
        eg[exp_g] = 1'b1;
        ew = req_we[exp_g];
        ea = req_addr[exp_g*AW +: AW];
        ed = req_wdata[exp_g*DW +: DW];
        em = ew ? req_be[exp_g*BW +: BW] : '0;
      end
      chk("req_ready", req_ready, eg);
      chk("mem_read_req", mem_read_req, (exp_g >= 0) && !ew);
      chk("mem_write_req", mem_write_req, (exp_g >= 0) && ew);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("mem_wmask", mem_wmask, em);
      chk("err_unexp", err_unexp, exp_err);
    end
  endtask

  // Advance one clock and apply the spec rules to the model.
  task automatic clk_step();
    int p;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      outst.delete();
      exp_rsp.delete();
      rr      = 0;
      exp_err = 1'b0;
    end else begin
      if (mem_read_data_valid) begin
        if (outst.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          p = outst.pop_front();
          exp_rsp.push_back('{port: p, data: mem_read_data, due: cyc});
        end
      end
      if (exp_g >= 0) begin
        if (!req_we[exp_g]) outst.push_back(exp_g);
        rr = (exp_g + 1) % NP;
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle_check();
    clk_step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every response strobe must match the oldest expected one.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid != '0) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_spurious", rsp_valid, 0);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_port", rsp_valid, 1 << e.port);
            chk("rsp_data", rsp_rdata, e.data);
            chk("rsp_cycle", cyc, e.due);
          end
        end else if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
          e = exp_rsp.pop_front();
          chk("rsp_missing", rsp_valid, 1 << e.port);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; rr = 0; exp_err = 1'b0; mon_en = 1'b0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset(2);
    mon_en = 1'b1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_err", err_unexp, 0);

    // Single-port read, data returned five cycles after issue.
    set_req(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    settle_check();
    chk("t1_ready", req_ready, 2'b10);
    clk_step();
    idle();
    repeat (4) tick();
    mem_read_data_valid = 1'b1;
    mem_read_data       = 32'hDEAD_BEEF;
    tick();
    mem_read_data_valid = 1'b0;
    chk("t1_rsp_valid", rsp_valid, 2'b10);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // Fairness: both ports always requesting, controller always ready.
    do_reset(1);
    set_req(0, 1'b1, 32'h10, 32'hA, 4'hF);
    set_req(1, 1'b1, 32'h20, 32'hB, 4'hF);
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("t2_fair", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      clk_step();
    end
    idle();

    // Outstanding limit with data withheld.
    do_reset(1);
    for (int i = 0; i < MO; i++) begin
      set_req(0, 1'b0, 32'h200 + i * 4, 32'h0, 4'h0);
      tick();
    end
    settle_check();
    chk("t3_stall", req_ready, 2'b00);
    clk_step();
    set_req(1, 1'b1, 32'h300, 32'h5555_AAAA, 4'hF);
    settle_check();
    chk("t3_wr_ok", req_ready, 2'b10);
    clk_step();
    req_valid[1] = 1'b0;
    mem_read_data_valid = 1'b1;
    mem_read_data       = 32'h0BAD_F00D;
    settle_check();
    chk("t3_full_pop", req_ready, 2'b00);
    clk_step();
    mem_read_data_valid = 1'b0;
    settle_check();
    chk("t3_resume", req_ready, 2'b01);
    clk_step();
    idle();
    repeat (MO) begin
      mem_read_data_valid = 1'b1;
      mem_read_data       = $urandom;
      tick();
    end
    mem_read_data_valid = 1'b0;
    repeat (2) tick();

    // Response steering: P0, P1, P0 then data A, B, C.
    do_reset(1);
    set_req(0, 1'b0, 32'h400, 32'h0, 4'h0); tick(); idle();
    set_req(1, 1'b0, 32'h404, 32'h0, 4'h0); tick(); idle();
    set_req(0, 1'b0, 32'h408, 32'h0, 4'h0); tick(); idle();
    mem_read_data_valid = 1'b1;
    mem_read_data = 32'hAAAA_0001; tick();
    chk("t4_a_port", rsp_valid, 2'b01);
    chk("t4_a_data", rsp_rdata, 32'hAAAA_0001);
    mem_read_data = 32'hBBBB_0002; tick();
    chk("t4_b_port", rsp_valid, 2'b10);
    chk("t4_b_data", rsp_rdata, 32'hBBBB_0002);
    mem_read_data = 32'hCCCC_0003; tick();
    chk("t4_c_port", rsp_valid, 2'b01);
    chk("t4_c_data", rsp_rdata, 32'hCCCC_0003);
    mem_read_data_valid = 1'b0;
    tick();
    chk("t4_hold", rsp_rdata, 32'hCCCC_0003);

    // Write with byte enables: posted, no response.
    set_req(0, 1'b1, 32'h500, 32'h1122_3344, 4'b0101);
    settle_check();
    chk("t5_wreq", mem_write_req, 1);
    chk("t5_wmask", mem_wmask, 4'b0101);
    chk("t5_wdata", mem_wdata, 32'h1122_3344);
    clk_step();
    idle();
    repeat (2) tick();
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_occ", outst.size(), 0);

    // Unexpected data: sticky error, cleared by reset.
    mem_read_data_valid = 1'b1;
    mem_read_data       = 32'h1234_5678;
    tick();
    mem_read_data_valid = 1'b0;
    chk("t6_err", err_unexp, 1);
    chk("t6_no_rsp", rsp_valid, 0);
    repeat (3) tick();
    chk("t6_sticky", err_unexp, 1);
    do_reset(1);
    chk("t6_clear", err_unexp, 0);

    // Randomized traffic with bursty controller return behaviour.
    for (int i = 0; i < 3000; i++) begin
      int slow;
      slow = ((i / 100) % 2 == 1) ? 8 : 2;
      for (int p = 0; p < NP; p++) begin
        req_valid[p]          = ($urandom_range(0, 3) != 0);
        req_we[p]             = $urandom_range(0, 1);
        req_addr[p*AW +: AW]  = $urandom;
        req_wdata[p*DW +: DW] = $urandom;
        req_be[p*BW +: BW]    = BW'($urandom);
      end
      mem_read_ready      = ($urandom_range(0, 4) != 0);
      mem_write_ready     = ($urandom_range(0, 4) != 0);
      mem_read_data_valid = (outst.size() > 0) && ($urandom_range(0, slow) == 0);
      mem_read_data       = $urandom;
      tick();
    end
    idle();
    for (int i = 0; i < 2 * MO && outst.size() > 0; i++) begin
      mem_read_data_valid = 1'b1;
      mem_read_data       = $urandom;
      tick();
    end
    mem_read_data_valid = 1'b0;
    repeat (3) tick();
    chk("drain_outst", outst.size(), 0);
    chk("drain_rsp", exp_rsp.size(), 0);
    chk("final_err", err_unexp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
